axis_stream_framer: RTL
=======================

// Module: axis_stream_framer
// PURPOSE
// - Merges CHANNELS independent byte-wide AXI-Stream sensor sources (accelerometer, future SPI/I2C sensors)
//   into one framed byte stream for the UART TX bridge.
// - Round-robin arbitration; each frame = SYNC byte, channel-ID byte, payload, optional checksum.
// - Generalises the single accelerometer->UART path to N channels with host-resynchronisable framing.
// PARAMETERS
// - CHANNELS     4      number of input streams, 1..16
// - PAYLOAD_MAX  16     max payload bytes per frame, 1..255
// - SYNC_BYTE    8'hA5  first byte of every frame
// PORTS
// - clk           in   1           system clock; all logic on rising edge
// - reset         in   1           synchronous, active-high
// - s_tdata       in   8*CHANNELS  channel i data at [8*i+7:8*i]
// - s_tvalid      in   CHANNELS    per-channel valid
// - s_tlast       in   CHANNELS    per-channel end-of-packet
// - s_tready      out  CHANNELS    per-channel ready; at most one bit high per cycle
// - m_tdata       out  8           framed output byte (registered)
// - m_tvalid      out  1           output valid (registered)
// - m_tlast       out  1           last byte of frame
// - m_tready      in   1           downstream ready (UART tx_stream)
// - active_chan   out  4           granted channel, valid while busy=1
// - busy          out  1           high from SYNC until the last frame byte is accepted
// - frame_count   out  16          completed frames, wraps 16'hFFFF->0
// BEHAVIOUR
// - Reset: m_tvalid=0, m_tdata=0, m_tlast=0, s_tready=0, busy=0, active_chan=0, frame_count=0,
//   rr_ptr=CHANNELS-1 (channel 0 wins first). Reset mid-frame abandons the frame immediately; no tail bytes.
// - Output register: loads when !m_tvalid || m_tready; holds m_tdata/m_tlast stable while m_tvalid && !m_tready.
// - FSM IDLE->SYNC->ID->PAYLOAD->[CSUM]->IDLE.
// - IDLE: pick the first i with s_tvalid[i], searching rr_ptr+1 .. rr_ptr+CHANNELS mod CHANNELS.
//   Latch grant, set rr_ptr=grant and busy=1, go to SYNC. No valid input: remain in IDLE.
// - SYNC: load SYNC_BYTE.
// - ID: load {4'h0, grant[3:0]}.
// - Each load happens when the output register is free; the state then advances.
// - PAYLOAD:
//   - s_tready[grant] = !m_tvalid || m_tready; all other s_tready bits 0.
//   - On s_tvalid && s_tready: load s_tdata[grant] and increment byte count.
//   - Frame ends when s_tlast=1 or count reaches PAYLOAD_MAX (truncation).
//   - On truncation, the source's remaining bytes start a new frame the next time that channel is granted.
// - m_tlast=1 on the final byte of the frame: the checksum byte if AXIS_FRAMER_CHECKSUM_EN is defined,
//   otherwise the last payload byte.
// - Frame done = handshake of the m_tlast byte. Then frame_count++, busy=0, go to IDLE.
//   IDLE re-arbitrates on the next cycle, so frames are separated by at least 1 idle cycle.
// - Minimum latency: s_tvalid in IDLE -> SYNC byte on m_tvalid 2 cycles later, given m_tready held high.
// - Throughput: 1 byte/cycle inside a frame while m_tready=1.
// - A source that drops s_tvalid mid-PAYLOAD stalls the frame; the grant is kept with no timeout.
// - A payload byte with s_tlast arriving at count==PAYLOAD_MAX-1 ends the frame once; no empty follow-up frame.
// - CHANNELS==1: arbitration is trivial and the ID byte is always 8'h00.
// CONFIGURATION
// - AXIS_FRAMER_CHECKSUM_EN defined:
//   - CSUM state after PAYLOAD emits the XOR of the ID byte and all payload bytes; m_tlast on that byte.
//   - Accumulator clears at SYNC.
// - AXIS_FRAMER_CHECKSUM_EN undefined: no CSUM state, no accumulator; frame length = 2 + payload bytes.
// TESTING
// - Reset, then ch0 sends 3 bytes 11,22,33 (tlast on 33), m_tready=1
//   -> out A5,00,11,22,33 (+ checksum 00 if enabled); m_tlast on final byte; frame_count=1.
// - ch1 and ch3 valid simultaneously after ch0 was last granted
//   -> ch1 frame first, then ch3; ID bytes 01 then 03; s_tready never two bits high.
// - PAYLOAD_MAX=4, ch2 sends 6-byte packet 01..06
//   -> frame1 A5,02,01,02,03,04 (tlast on 04 if checksum disabled); frame2 A5,02,05,06.
// - m_tready toggled 1/0 each cycle during payload
//   -> no byte lost or duplicated; m_tdata/m_tlast stable while stalled.
// - Reset asserted after ID byte accepted
//   -> next cycle m_tvalid=0, s_tready=0, busy=0, frame_count unchanged at reset value 0; next frame starts with A5.
// - CHECKSUM_EN, ch3 bytes F0,0F,AA -> checksum 03^F0^0F^AA = 56 emitted with m_tlast;
//   frame_count 16'hFFFF -> 0 on the next completed frame.

Source files
------------

// File: rtl/axis_stream_framer.sv
// Round-robin merger of CHANNELS byte-wide AXI-Stream sources into SYNC/ID/payload frames.
// Optional trailing XOR checksum byte is enabled by defining AXIS_FRAMER_CHECKSUM_EN.
module axis_stream_framer #(
    parameter int         CHANNELS    = 4,
    parameter int         PAYLOAD_MAX = 16,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*CHANNELS-1:0] s_tdata,
    input  logic [CHANNELS-1:0]   s_tvalid,
    input  logic [CHANNELS-1:0]   s_tlast,
    output logic [CHANNELS-1:0]   s_tready,
    output logic [7:0]            m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic [3:0]            active_chan,
    output logic                  busy,
    output logic [15:0]           frame_count
);

`ifdef AXIS_FRAMER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, SYNC, ID, PAYLOAD, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, ID, PAYLOAD, DONE} state_t;
`endif

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_MAX - 1);

    state_t      state, next_state;
    logic [3:0]  grant, rr_ptr, pick;
    logic [7:0]  count;
    logic        pick_valid;
    int          arb_idx;
    logic [7:0]  sel_data;
    logic        sel_valid, sel_last;
    logic        load_en, out_load, out_last, take, frame_done, ready_grant;
    logic [7:0]  out_data;
`ifdef AXIS_FRAMER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign load_en     = !m_tvalid || m_tready;
    assign busy        = (state != IDLE);
    assign active_chan = grant;

    // First requester after the previously granted channel wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        arb_idx    = 0;
        for (int k = 1; k <= CHANNELS; k++) begin
            arb_idx = (int'(rr_ptr) + k) % CHANNELS;
            if (!pick_valid && s_tvalid[arb_idx]) begin
                pick       = 4'(arb_idx);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        s_tready  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == 4'(i)) begin
                sel_data    = s_tdata[8*i +: 8];
                sel_valid   = s_tvalid[i];
                sel_last    = s_tlast[i];
                s_tready[i] = ready_grant;
            end
        end
    end

    always_comb begin
        next_state  = state;
        out_load    = 1'b0;
        out_data    = m_tdata;
        out_last    = 1'b0;
        ready_grant = 1'b0;
        take        = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: if (pick_valid) next_state = SYNC;
            SYNC: if (load_en) begin
                out_load   = 1'b1;
                out_data   = SYNC_BYTE;
                next_state = ID;
            end
            ID: if (load_en) begin
                out_load   = 1'b1;
                out_data   = {4'h0, grant};
                next_state = PAYLOAD;
            end
            PAYLOAD: begin
                ready_grant = load_en;
                if (load_en && sel_valid) begin
                    take     = 1'b1;
                    out_load = 1'b1;
                    out_data = sel_data;
                    if (sel_last || count == LAST_IDX) begin
`ifdef AXIS_FRAMER_CHECKSUM_EN
                        next_state = CSUM;
`else
                        out_last   = 1'b1;
                        next_state = DONE;
`endif
                    end
                end
            end
`ifdef AXIS_FRAMER_CHECKSUM_EN
            CSUM: if (load_en) begin
                out_load   = 1'b1;
                out_data   = csum;
                out_last   = 1'b1;
                next_state = DONE;
            end
`endif
            // The tlast byte sits in the output register until the sink takes it.
            DONE: if (m_tvalid && m_tready) begin
                frame_done = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= 4'(CHANNELS - 1);
            count       <= '0;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tlast     <= 1'b0;
            frame_count <= '0;
`ifdef AXIS_FRAMER_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            state <= next_state;
            if (state == IDLE && pick_valid) begin
                grant  <= pick;
                rr_ptr <= pick;
            end
            if (state == SYNC)
                count <= '0;
            else if (take)
                count <= count + 8'd1;
            if (load_en) begin
                m_tvalid <= out_load;
                if (out_load) begin
                    m_tdata <= out_data;
                    m_tlast <= out_last;
                end
            end
            if (frame_done)
                frame_count <= frame_count + 16'd1;
`ifdef AXIS_FRAMER_CHECKSUM_EN
            // Covers the ID byte and every payload byte, but not the SYNC byte.
            if (state == SYNC)
                csum <= '0;
            else if (out_load && state != CSUM)
                csum <= csum ^ out_data;
`endif
        end
    end

endmodule
